// File: rtl/bus_mem_slave.sv
// bus_mem_slave: word-addressed RAM responder with programmable ack latency and byte-masked writes
module bus_mem_slave #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned LATENCY   = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_bus_en,
   input  logic        i_wr_en,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wr_data,
   input  logic [3:0]  i_byte_en,
   output logic        o_ack,
   output logic [31:0] o_rd_data
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 2;
   if (LATENCY < 1 || LATENCY > 15 || MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0 ||
       (33'(BASE_ADDR) % SPAN) != 0) begin : g_bad_param
      $error("bus_mem_slave: illegal MEM_WORDS/BASE_ADDR/LATENCY");
   end
   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic          hit_q, hit_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [31:0]   data_q, data_d;
   logic [3:0]    be_q, be_d;
   logic          ack_q;
   logic [31:0]   rd_q;
   logic [31:0]   off;
   logic          go_ack;
   logic [31:0]   mem [MEM_WORDS];
   // an address below BASE_ADDR wraps to a huge offset, so one unsigned compare covers both bounds
   assign off    = i_addr - BASE_ADDR;
   // the _d request fields are what the ACK-entry edge must use, which also covers LATENCY==1
   assign go_ack = state_d == ACK;
   assign o_ack     = ack_q;
   assign o_rd_data = rd_q;
   // next-state: latch request in IDLE, count down in WAIT, single-cycle ACK
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      hit_d   = hit_q;
      idx_d   = idx_q;
      data_d  = data_q;
      be_d    = be_q;
      case (state_q)
         IDLE: if (i_bus_en) begin
            wr_d    = i_wr_en;
            hit_d   = {1'b0, off} < SPAN;
            idx_d   = off[AW+1:2];
            data_d  = i_wr_data;
            be_d    = i_byte_en;
            cnt_d   = 4'(LATENCY - 1);
            state_d = LATENCY == 1 ? ACK : WAIT;
         end
         WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd1 ? ACK : WAIT;
         end
         default: state_d = IDLE;
      endcase
   end
   // control and output registers; reset discards any latched request
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         hit_q   <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
         be_q    <= '0;
         ack_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         hit_q   <= hit_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         be_q    <= be_d;
         ack_q   <= go_ack;
         if (go_ack && !wr_d) rd_q <= hit_d ? mem[idx_d] : 32'h0;
      end
   end
   // RAM array is never cleared; a write commits only on an unreset edge entering ACK
   always_ff @(posedge i_clk) begin
      if (i_rst && go_ack && wr_d && hit_d)
         for (int b = 0; b < 4; b++)
            if (be_d[b]) mem[idx_d][8*b +: 8] <= data_d[8*b +: 8];
   end
endmodule

// File: tb/tb_bus_mem_slave.sv
// tb_bus_mem_slave: directed checks of three differently parameterised bus_mem_slave instances
module tb_bus_mem_slave;
   logic             clk = 1'b0;
   logic             rst_n;
   logic [2:0]       en;
   logic             wr;
   logic [31:0]      addr, wdata;
   logic [3:0]       be;
   logic [2:0]       ack;
   logic [2:0][31:0] rd;
   int               pass_cnt = 0;
   int               total = 0;
   always #5 clk = ~clk;
   bus_mem_slave #(.MEM_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(1)) u0 (
      .i_clk(clk), .i_rst(rst_n), .i_bus_en(en[0]), .i_wr_en(wr), .i_addr(addr),
      .i_wr_data(wdata), .i_byte_en(be), .o_ack(ack[0]), .o_rd_data(rd[0]));
   bus_mem_slave #(.MEM_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(4)) u1 (
      .i_clk(clk), .i_rst(rst_n), .i_bus_en(en[1]), .i_wr_en(wr), .i_addr(addr),
      .i_wr_data(wdata), .i_byte_en(be), .o_ack(ack[1]), .o_rd_data(rd[1]));
   bus_mem_slave #(.MEM_WORDS(16), .BASE_ADDR(32'h100), .LATENCY(3)) u2 (
      .i_clk(clk), .i_rst(rst_n), .i_bus_en(en[2]), .i_wr_en(wr), .i_addr(addr),
      .i_wr_data(wdata), .i_byte_en(be), .o_ack(ack[2]), .o_rd_data(rd[2]));
   // one transaction on instance s; lat counts cycles from accept to ack, tail is ack one cycle later
   task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output int lat, output logic [31:0] r, output logic tail);
      en[s] = 1'b1; wr = w; addr = a; wdata = d; be = b;
      @(posedge clk); #1;
      en[s] = 1'b0;
      lat = 1;
      while (!ack[s] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      r = rd[s];
      @(posedge clk); #1;
      tail = ack[s];
   endtask
   task automatic test_reset();
      rst_n = 1'b0; en = '0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         total++;
         if (ack[s] !== 1'b0) $display("FAIL reset_ack[%0d] got %b want 0", s, ack[s]); else pass_cnt++;
         total++;
         if (rd[s] !== 32'h0) $display("FAIL reset_rd[%0d] got %h want 0", s, rd[s]); else pass_cnt++;
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask
   task automatic test_basic();
      int lat; logic [31:0] r; logic t;
      issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, r, t);
      total++;
      if (lat !== 1) $display("FAIL basic_wr_lat got %0d want 1", lat); else pass_cnt++;
      total++;
      if (t !== 1'b0) $display("FAIL basic_wr_ack_width got %b want 0", t); else pass_cnt++;
      issue(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, r, t);
      total++;
      if (lat !== 1) $display("FAIL basic_rd_lat got %0d want 1", lat); else pass_cnt++;
      total++;
      if (r !== 32'hDEADBEEF) $display("FAIL basic_rd_data got %h want deadbeef", r); else pass_cnt++;
      total++;
      if (t !== 1'b0) $display("FAIL basic_rd_ack_width got %b want 0", t); else pass_cnt++;
   endtask
   task automatic test_byte_lanes();
      int lat; logic [31:0] r; logic t;
      issue(1, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, r, t);
      total++;
      if (lat !== 4) $display("FAIL lanes_wr_lat got %0d want 4", lat); else pass_cnt++;
      issue(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, r, t);
      issue(1, 1'b0, 32'h20, 32'h0, 4'h0, lat, r, t);
      total++;
      if (lat !== 4) $display("FAIL lanes_rd_lat got %0d want 4", lat); else pass_cnt++;
      total++;
      if (r !== 32'h11BB33DD) $display("FAIL lanes_rd_data got %h want 11bb33dd", r); else pass_cnt++;
      total++;
      if (t !== 1'b0) $display("FAIL lanes_ack_width got %b want 0", t); else pass_cnt++;
   endtask
   task automatic test_back_to_back();
      int lat, n, cyc, last; logic [31:0] r; logic t;
      logic [31:0] exp_d [3];
      exp_d[0] = 32'hA0A0A0A0; exp_d[1] = 32'hB1B1B1B1; exp_d[2] = 32'hC2C2C2C2;
      for (int i = 0; i < 3; i++) issue(0, 1'b1, 32'(4 * i), exp_d[i], 4'hF, lat, r, t);
      en[0] = 1'b1; wr = 1'b0; addr = 32'h0;
      n = 0; cyc = 0; last = 0;
      while (n < 3 && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
         if (ack[0]) begin
            total++;
            if (rd[0] !== exp_d[n]) $display("FAIL b2b_data[%0d] got %h want %h", n, rd[0], exp_d[n]); else pass_cnt++;
            total++;
            if (cyc - last !== (n == 0 ? 1 : 2)) $display("FAIL b2b_spacing[%0d] got %0d want %0d", n, cyc - last, n == 0 ? 1 : 2); else pass_cnt++;
            last = cyc;
            n++;
            addr = 32'(4 * n);
         end
      end
      en[0] = 1'b0;
      total++;
      if (n !== 3) $display("FAIL b2b_count got %0d want 3", n); else pass_cnt++;
      @(posedge clk); #1;
      total++;
      if (ack[0] !== 1'b0) $display("FAIL b2b_idle_ack got %b want 0", ack[0]); else pass_cnt++;
   endtask
   task automatic test_out_of_range();
      int lat; logic [31:0] r; logic t;
      issue(0, 1'b0, 32'h40, 32'h0, 4'h0, lat, r, t);
      total++;
      if (lat !== 1) $display("FAIL oor_rd_lat got %0d want 1", lat); else pass_cnt++;
      total++;
      if (r !== 32'h0) $display("FAIL oor_rd_data got %h want 0", r); else pass_cnt++;
      issue(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, lat, r, t);
      total++;
      if (lat !== 1) $display("FAIL oor_wr_lat got %0d want 1", lat); else pass_cnt++;
      issue(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, r, t);
      total++;
      if (r !== 32'hA0A0A0A0) $display("FAIL oor_word0 got %h want a0a0a0a0", r); else pass_cnt++;
      issue(0, 1'b1, 32'h4, 32'h0, 4'h0, lat, r, t);
      issue(0, 1'b0, 32'h4, 32'h0, 4'h0, lat, r, t);
      total++;
      if (r !== 32'hB1B1B1B1) $display("FAIL be_zero_word1 got %h want b1b1b1b1", r); else pass_cnt++;
      issue(0, 1'b0, 32'h9, 32'h0, 4'h0, lat, r, t);
      total++;
      if (r !== 32'hC2C2C2C2) $display("FAIL misaligned_rd got %h want c2c2c2c2", r); else pass_cnt++;
   endtask
   task automatic test_reset_mid_op();
      int lat, acks; logic [31:0] r; logic t;
      issue(1, 1'b1, 32'h8, 32'h12345678, 4'hF, lat, r, t);
      en[1] = 1'b1; wr = 1'b1; addr = 32'h8; wdata = 32'h5; be = 4'hF;
      @(posedge clk); #1;
      en[1] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++;
      if (rd[1] !== 32'h0) $display("FAIL midrst_rd got %h want 0", rd[1]); else pass_cnt++;
      acks = 0;
      for (int c = 0; c < 6; c++) begin
         if (ack[1]) acks++;
         @(posedge clk); #1;
      end
      total++;
      if (acks !== 0) $display("FAIL midrst_ack got %0d acks want 0", acks); else pass_cnt++;
      issue(1, 1'b0, 32'h8, 32'h0, 4'h0, lat, r, t);
      total++;
      if (r !== 32'h12345678) $display("FAIL midrst_old_value got %h want 12345678", r); else pass_cnt++;
      total++;
      if (lat !== 4) $display("FAIL midrst_rd_lat got %0d want 4", lat); else pass_cnt++;
   endtask
   task automatic test_request_drop();
      int lat, n, first; logic [31:0] r, seen; logic t;
      issue(2, 1'b1, 32'h104, 32'hCAFEF00D, 4'hF, lat, r, t);
      issue(2, 1'b1, 32'h108, 32'h0BADBEEF, 4'hF, lat, r, t);
      en[2] = 1'b1; wr = 1'b0; addr = 32'h104;
      @(posedge clk); #1;
      en[2] = 1'b0; addr = 32'h108; wr = 1'b1; wdata = 32'hFFFFFFFF; be = 4'hF;
      n = 0; first = 0; seen = '0;
      for (int c = 1; c <= 8; c++) begin
         if (ack[2]) begin
            n++; first = c; seen = rd[2];
         end
         @(posedge clk); #1;
      end
      total++;
      if (n !== 1) $display("FAIL drop_ack_count got %0d want 1", n); else pass_cnt++;
      total++;
      if (first !== 3) $display("FAIL drop_lat got %0d want 3", first); else pass_cnt++;
      total++;
      if (seen !== 32'hCAFEF00D) $display("FAIL drop_data got %h want cafef00d", seen); else pass_cnt++;
      issue(2, 1'b0, 32'h108, 32'h0, 4'h0, lat, r, t);
      total++;
      if (r !== 32'h0BADBEEF) $display("FAIL drop_no_write got %h want 0badbeef", r); else pass_cnt++;
      issue(2, 1'b0, 32'h0FC, 32'h0, 4'h0, lat, r, t);
      total++;
      if (r !== 32'h0) $display("FAIL below_base got %h want 0", r); else pass_cnt++;
      issue(2, 1'b0, 32'h140, 32'h0, 4'h0, lat, r, t);
      total++;
      if (r !== 32'h0) $display("FAIL above_top got %h want 0", r); else pass_cnt++;
      total++;
      if (lat !== 3) $display("FAIL above_top_lat got %0d want 3", lat); else pass_cnt++;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_basic();
      test_byte_lanes();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_op();
      test_request_drop();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
